// File: rtl/pc_trace_monitor.sv
// Fetch-PC stream observer: queues (from,to) pairs for control-flow discontinuities,
// counts samples and jumps, and latches a halt once the PC stops advancing.
module pc_trace_monitor #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 8,
  parameter int HALT_CYCLES = 4,
  parameter int CNT_W       = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        final_address,
  input  logic                     enable,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [ADDR_W-1:0]        trace_from,
  output logic [ADDR_W-1:0]        trace_to,
  output logic                     trace_overflow,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         jump_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SR_W  = $clog2(HALT_CYCLES + 1);

  logic [ADDR_W-1:0] mem_from [DEPTH];
  logic [ADDR_W-1:0] mem_to   [DEPTH];
  logic [PTR_W:0]    rd_ptr;
  logic [PTR_W:0]    wr_ptr;
  logic [ADDR_W-1:0] prev_addr;
  logic              primed;
  logic [SR_W-1:0]   stall_run;

  logic              sample;
  logic              is_stall;
  logic              is_jump;
  logic              push;
  logic              pop;
  logic              full;
  logic              wr_en;

  always_comb begin
    sample      = enable && !halted;
    is_stall    = (final_address == prev_addr);
    is_jump     = primed && !is_stall && (final_address != (prev_addr + ADDR_W'(4)));
    push        = sample && is_jump;
    fifo_level  = wr_ptr - rd_ptr;
    trace_valid = (wr_ptr != rd_ptr);
    full        = (fifo_level == (PTR_W + 1)'(DEPTH));
    pop         = trace_valid && trace_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    wr_en       = push && (!full || pop);
    trace_from  = trace_valid ? mem_from[rd_ptr[PTR_W-1:0]] : '0;
    trace_to    = trace_valid ? mem_to[rd_ptr[PTR_W-1:0]]   : '0;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_from[wr_ptr[PTR_W-1:0]] <= prev_addr;
      mem_to[wr_ptr[PTR_W-1:0]]   <= final_address;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !wr_en) begin
        trace_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_addr   <= '0;
      primed      <= 1'b0;
      stall_run   <= '0;
      halted      <= 1'b0;
      cycle_count <= '0;
      jump_count  <= '0;
    end else if (sample) begin
      prev_addr <= final_address;
      primed    <= 1'b1;
      if (cycle_count != '1) begin
        cycle_count <= cycle_count + 1'b1;
      end
      if (primed) begin
        if (is_stall) begin
          if (stall_run != SR_W'(HALT_CYCLES)) begin
            stall_run <= stall_run + 1'b1;
          end
          // Halt on the edge where the run reaches HALT_CYCLES repeats.
          if (stall_run == SR_W'(HALT_CYCLES - 1)) begin
            halted <= 1'b1;
          end
        end else begin
          stall_run <= '0;
        end
        if (is_jump && (jump_count != '1)) begin
          jump_count <= jump_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_trace_monitor.sv
// Scoreboard bench for pc_trace_monitor: stimulus pushes hand-computed trace pairs,
// a negedge monitor pops and compares every accepted head entry.
module tb_pc_trace_monitor;

  logic        clock;
  logic        reset;
  logic [31:0] final_address;
  logic        enable;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_from;
  logic [31:0] trace_to;
  logic        trace_overflow;
  logic [3:0]  fifo_level;
  logic        halted;
  logic [31:0] cycle_count;
  logic [31:0] jump_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q [$];

  pc_trace_monitor #(
    .ADDR_W(32), .DEPTH(8), .HALT_CYCLES(4), .CNT_W(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .final_address(final_address),
    .enable(enable),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_from(trace_from),
    .trace_to(trace_to),
    .trace_overflow(trace_overflow),
    .fifo_level(fifo_level),
    .halted(halted),
    .cycle_count(cycle_count),
    .jump_count(jump_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every handshake seen here pops the head on the next rising edge.
  always @(negedge clock) begin
    if (!reset && trace_valid && trace_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL trace_unexpected: got from=0x%0h to=0x%0h, expected no entry",
                 trace_from, trace_to);
      end else begin
        logic [63:0] exp_pair;
        exp_pair = exp_q.pop_front();
        if ({trace_from, trace_to} !== exp_pair) begin
          errors++;
          $display("[TB] FAIL trace_pair: got from=0x%0h to=0x%0h, expected from=0x%0h to=0x%0h",
                   trace_from, trace_to, exp_pair[63:32], exp_pair[31:0]);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic en);
    final_address = addr;
    enable        = en;
    @(posedge clock);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check_output({tag, "_valid"},    64'(trace_valid),    64'd0);
    check_output({tag, "_from"},     64'(trace_from),     64'd0);
    check_output({tag, "_to"},       64'(trace_to),       64'd0);
    check_output({tag, "_overflow"}, 64'(trace_overflow), 64'd0);
    check_output({tag, "_level"},    64'(fifo_level),     64'd0);
    check_output({tag, "_halted"},   64'(halted),         64'd0);
    check_output({tag, "_cycles"},   64'(cycle_count),    64'd0);
    check_output({tag, "_jumps"},    64'(jump_count),     64'd0);
  endtask

  // Called at posedge+1; reset pulse stays between edges.
  task automatic do_reset(input string tag);
    enable      = 1'b0;
    trace_ready = 1'b0;
    reset       = 1'b1;
    exp_q.delete();
    #2;
    check_cleared(tag);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    enable        = 1'b0;
    trace_ready   = 1'b0;
    final_address = '0;
    @(posedge clock);
    #1;

    // Test 1: sequential run
    do_reset("rst1");
    trace_ready = 1'b1;
    for (int i = 0; i <= 8; i++) apply_stimulus(32'(i * 4), 1'b1);
    check_output("t1_valid",  64'(trace_valid), 64'd0);
    check_output("t1_cycles", 64'(cycle_count), 64'd9);
    check_output("t1_jumps",  64'(jump_count),  64'd0);

    // Test 2: single jump with ready high
    do_reset("rst2");
    trace_ready = 1'b1;
    apply_stimulus(32'h0, 1'b1);
    apply_stimulus(32'h4, 1'b1);
    apply_stimulus(32'h8, 1'b1);
    exp_q.push_back({32'h8, 32'h40});
    apply_stimulus(32'h40, 1'b1);
    check_output("t2_valid_after_jump", 64'(trace_valid), 64'd1);
    check_output("t2_from", 64'(trace_from), 64'h8);
    check_output("t2_to",   64'(trace_to),   64'h40);
    apply_stimulus(32'h44, 1'b1);
    check_output("t2_valid_after_pop", 64'(trace_valid), 64'd0);
    check_output("t2_jumps",  64'(jump_count),  64'd1);
    check_output("t2_cycles", 64'(cycle_count), 64'd5);

    // Test 3: overflow with ready low, then drain
    do_reset("rst3");
    apply_stimulus(32'h0, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      if (k <= 8) exp_q.push_back({32'((k - 1) * 32'h100), 32'(k * 32'h100)});
      apply_stimulus(32'(k * 32'h100), 1'b1);
    end
    check_output("t3_level",    64'(fifo_level),     64'd8);
    check_output("t3_overflow", 64'(trace_overflow), 64'd1);
    check_output("t3_jumps",    64'(jump_count),     64'd9);
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) apply_stimulus(32'h0, 1'b0);
    check_output("t3_drained_valid", 64'(trace_valid), 64'd0);
    check_output("t3_queue_empty",   64'(exp_q.size()), 64'd0);

    // Test 4: full FIFO, pop and push on the same edge
    do_reset("rst4");
    apply_stimulus(32'h0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({32'((k - 1) * 32'h100), 32'(k * 32'h100)});
      apply_stimulus(32'(k * 32'h100), 1'b1);
    end
    check_output("t4_level_full", 64'(fifo_level), 64'd8);
    trace_ready = 1'b1;
    exp_q.push_back({32'h800, 32'h900});
    apply_stimulus(32'h900, 1'b1);
    trace_ready = 1'b0;
    check_output("t4_level_after", 64'(fifo_level),     64'd8);
    check_output("t4_overflow",    64'(trace_overflow), 64'd0);
    check_output("t4_jumps",       64'(jump_count),     64'd9);
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) apply_stimulus(32'h0, 1'b0);
    check_output("t4_drained_valid", 64'(trace_valid),  64'd0);
    check_output("t4_queue_empty",   64'(exp_q.size()), 64'd0);

    // Test 5: halt detection and freeze
    do_reset("rst5");
    trace_ready = 1'b1;
    apply_stimulus(32'h18, 1'b1);
    for (int i = 0; i < 4; i++) apply_stimulus(32'h1C, 1'b1);
    check_output("t5_not_halted_yet", 64'(halted), 64'd0);
    apply_stimulus(32'h1C, 1'b1);
    check_output("t5_halted", 64'(halted),      64'd1);
    check_output("t5_cycles", 64'(cycle_count), 64'd6);
    apply_stimulus(32'h80, 1'b1);
    apply_stimulus(32'h84, 1'b1);
    check_output("t5_cycles_frozen", 64'(cycle_count), 64'd6);
    check_output("t5_jumps_frozen",  64'(jump_count),  64'd0);
    check_output("t5_level",         64'(fifo_level),  64'd0);

    // Test 6: address wrap, enable low, reset during drain
    do_reset("rst6");
    trace_ready = 1'b1;
    apply_stimulus(32'hFFFF_FFF8, 1'b1);
    apply_stimulus(32'hFFFF_FFFC, 1'b1);
    apply_stimulus(32'h0, 1'b1);
    check_output("t6_wrap_jumps",  64'(jump_count),  64'd0);
    check_output("t6_wrap_cycles", 64'(cycle_count), 64'd3);
    apply_stimulus(32'h1234, 1'b0);
    apply_stimulus(32'h5678, 1'b0);
    check_output("t6_hold_cycles", 64'(cycle_count), 64'd3);
    check_output("t6_hold_jumps",  64'(jump_count),  64'd0);
    apply_stimulus(32'h4, 1'b1);
    check_output("t6_resume_jumps",  64'(jump_count),  64'd0);
    check_output("t6_resume_cycles", 64'(cycle_count), 64'd4);
    trace_ready = 1'b0;
    exp_q.push_back({32'h4, 32'h100});
    exp_q.push_back({32'h100, 32'h200});
    apply_stimulus(32'h100, 1'b1);
    apply_stimulus(32'h200, 1'b1);
    trace_ready = 1'b1;
    apply_stimulus(32'h0, 1'b0);
    check_output("t6_level_mid_drain", 64'(fifo_level), 64'd1);
    do_reset("t6_mid_drain");
    apply_stimulus(32'h0, 1'b0);
    check_output("t6_post_reset_valid", 64'(trace_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
